// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and pixel address field widths.
// Imported by the timing generator, scaler and colorizer.
package vga_timing_pkg;

   localparam int DEF_H_VIS  = 1024;
   localparam int DEF_H_FP   = 24;
   localparam int DEF_H_SYNC = 136;
   localparam int DEF_H_BP   = 160;
   localparam int DEF_V_VIS  = 768;
   localparam int DEF_V_FP   = 3;
   localparam int DEF_V_SYNC = 6;
   localparam int DEF_V_BP   = 29;

   localparam int COL_W  = 10;
   localparam int ROW_W  = 10;
   localparam int ADDR_W = COL_W + ROW_W;
   localparam int CNT_W  = 11;

   function automatic int span_total(
      input int vis,
      input int fp,
      input int sync,
      input int bp
   );
      return vis + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL =
      span_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL =
      span_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   // Signals that travel down the sync delay line together.
   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
   } sync_t;

   // Blanked, both syncs inactive (high).
   localparam sync_t SYNC_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with a loadable reset value.
// DEPTH=0 degenerates to a straight wire.
module sync_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused;
         assign unused = ^{clk, rst_n, rst_val};
         assign dout   = din;
      end else begin : g_sr
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift one stage per clock; reset fills every stage.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= rst_val;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/display_timing_gen.sv
// Free-running VGA timing generator (1024x768@60 by default).
// Syncs/video_on are delayed to match the colour pipeline.
import vga_timing_pkg::*;

module display_timing_gen #(
   parameter int H_VIS      = DEF_H_VIS,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_VIS      = DEF_V_VIS,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int SYNC_DELAY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              frame_start,
   output logic              video_on,
   output logic              horiz_sync,
   output logic              vert_sync
);

   localparam int H_TOTAL = span_total(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_VIS, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             vis_c;
   logic             hs_c;
   logic             vs_c;
   sync_t            s1;
   sync_t            dly;

   assign h_wrap = (h_cnt == H_LAST);

   // Raster counters: column every clock, row on column wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign vis_c = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
   assign hs_c  = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
   assign vs_c  = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));

   // Stage 1: register address, frame marker and raw syncs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_addr  <= '0;
         frame_start <= 1'b0;
         s1          <= SYNC_IDLE;
      end else begin
         pixel_addr  <= vis_c ? {h_cnt[COL_W-1:0], v_cnt[ROW_W-1:0]}
                              : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         s1          <= '{vis: vis_c, hs: hs_c, vs: vs_c};
      end
   end

   sync_delay_line #(
      .WIDTH ($bits(sync_t)),
      .DEPTH (SYNC_DELAY)
   ) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (SYNC_IDLE),
      .din     (s1),
      .dout    (dly)
   );

   assign video_on   = dly.vis;
   assign horiz_sync = dly.hs;
   assign vert_sync  = dly.vs;

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench for display_timing_gen: three full-size
// instances (delay 0/2/5) and one small-raster instance (delay 3).
module tb_display_timing_gen;

   typedef struct packed {
      logic [19:0] addr;
      logic        fs;
      logic        von;
      logic        hs;
      logic        vs;
   } obs_t;

   localparam obs_t RST_OBS = '{addr: 20'h0, fs: 1'b0, von: 1'b0,
                                hs: 1'b1, vs: 1'b1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] addr [4];
   logic        fs   [4];
   logic        von  [4];
   logic        hs   [4];
   logic        vs   [4];

   int k = -1;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   display_timing_gen #(.SYNC_DELAY(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .pixel_addr(addr[0]),
      .frame_start(fs[0]), .video_on(von[0]),
      .horiz_sync(hs[0]), .vert_sync(vs[0]));

   display_timing_gen #(.SYNC_DELAY(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .pixel_addr(addr[1]),
      .frame_start(fs[1]), .video_on(von[1]),
      .horiz_sync(hs[1]), .vert_sync(vs[1]));

   display_timing_gen #(.SYNC_DELAY(5)) u_d5 (
      .clk(clk), .rst_n(rst_n), .pixel_addr(addr[2]),
      .frame_start(fs[2]), .video_on(von[2]),
      .horiz_sync(hs[2]), .vert_sync(vs[2]));

   display_timing_gen #(
      .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_DELAY(3)
   ) u_sm (
      .clk(clk), .rst_n(rst_n), .pixel_addr(addr[3]),
      .frame_start(fs[3]), .video_on(von[3]),
      .horiz_sync(hs[3]), .vert_sync(vs[3]));

   function automatic int dly_of(input int i);
      case (i)
         0: return 0;
         1: return 2;
         2: return 5;
         default: return 3;
      endcase
   endfunction

   // Position-based reference: edge k since release shows raster
   // position k; delayed signals show position k-d.
   function automatic obs_t model(input int kk, input int i);
      int hv, hf, hw, vv, vf, vw, ht, vt, h, v, q, d;
      obs_t o;
      d = dly_of(i);
      if (i == 3) begin
         hv = 16; hf = 2; hw = 4; ht = 25;
         vv = 8; vf = 1; vw = 2; vt = 13;
      end else begin
         hv = 1024; hf = 24; hw = 136; ht = 1344;
         vv = 768; vf = 3; vw = 6; vt = 806;
      end
      o = RST_OBS;
      if (kk >= 0) begin
         h = kk % ht;
         v = (kk / ht) % vt;
         if (h < hv && v < vv) o.addr = {h[9:0], v[9:0]};
         o.fs = (h == 0 && v == 0);
      end
      q = kk - d;
      if (kk >= 0 && q >= 0) begin
         h = q % ht;
         v = (q / ht) % vt;
         o.von = (h < hv && v < vv);
         o.hs = !(h >= hv + hf && h < hv + hf + hw);
         o.vs = !(v >= vv + vf && v < vv + vf + vw);
      end
      return o;
   endfunction

   function automatic obs_t act(input int i);
      return '{addr: addr[i], fs: fs[i], von: von[i],
               hs: hs[i], vs: vs[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) k = k + 1;
      else k = -1;
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(5);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (act(i) !== RST_OBS) begin
            n_fail++;
            $display("FAIL reset inst%0d got %h exp %h",
                     i, act(i), RST_OBS);
         end
      end
   endtask

   task automatic test_startup();
      do_reset(2);
      for (int j = 0; j < 40; j++) begin
         tick();
         n_checks++;
         if ({addr[1], fs[1]} !== {model(k, 1).addr, model(k, 1).fs})
         begin
            n_fail++;
            $display("FAIL startup k=%0d got %h/%b exp %h/%b", k,
                     addr[1], fs[1], model(k, 1).addr, model(k, 1).fs);
         end
      end
   endtask

   task automatic test_alignment();
      int first [4];
      do_reset(3);
      for (int i = 0; i < 4; i++) first[i] = -1;
      for (int j = 0; j < 12; j++) begin
         tick();
         for (int i = 0; i < 4; i++)
            if (von[i] === 1'b1 && first[i] < 0) first[i] = k;
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (first[i] !== dly_of(i)) begin
            n_fail++;
            $display("FAIL align inst%0d video_on rose at E%0d exp E%0d",
                     i, first[i], dly_of(i));
         end
      end
   endtask

   task automatic test_hsync();
      int falls[$];
      int rises[$];
      logic prev;
      do_reset(2);
      prev = hs[1];
      for (int j = 0; j < 3 * 1344 + 200; j++) begin
         tick();
         n_checks++;
         if (act(1) !== model(k, 1)) begin
            n_fail++;
            $display("FAIL hline k=%0d got %h exp %h",
                     k, act(1), model(k, 1));
         end
         if (prev === 1'b1 && hs[1] === 1'b0) falls.push_back(k);
         if (prev === 1'b0 && hs[1] === 1'b1) rises.push_back(k);
         prev = hs[1];
         if (k == 1023) begin
            n_checks++;
            if (addr[1] !== {10'd1023, 10'd0}) begin
               n_fail++;
               $display("FAIL line_end got %h exp %h",
                        addr[1], {10'd1023, 10'd0});
            end
         end
         if (k == 1344) begin
            n_checks++;
            if (addr[1] !== {10'd0, 10'd1}) begin
               n_fail++;
               $display("FAIL next_line got %h exp %h",
                        addr[1], {10'd0, 10'd1});
            end
         end
      end
      n_checks++;
      if (falls.size() < 2 || rises.size() < 1) begin
         n_fail++;
         $display("FAIL hs_edges got %0d falls %0d rises exp >=2/>=1",
                  falls.size(), rises.size());
      end else begin
         if (falls[0] !== 1050) begin
            n_fail++;
            $display("FAIL hs_fall got E%0d exp E1050", falls[0]);
         end
         n_checks++;
         if (rises[0] - falls[0] !== 136) begin
            n_fail++;
            $display("FAIL hs_width got %0d exp 136",
                     rises[0] - falls[0]);
         end
         n_checks++;
         if (falls[1] - falls[0] !== 1344) begin
            n_fail++;
            $display("FAIL hs_period got %0d exp 1344",
                     falls[1] - falls[0]);
         end
      end
   endtask

   task automatic test_small_frame();
      int vfall[$];
      int vrise[$];
      int fsq[$];
      logic prev;
      do_reset(2);
      prev = vs[3];
      for (int j = 0; j < 3 * 325 + 20; j++) begin
         tick();
         n_checks++;
         if (act(3) !== model(k, 3)) begin
            n_fail++;
            $display("FAIL frame k=%0d got %h exp %h",
                     k, act(3), model(k, 3));
         end
         if (prev === 1'b1 && vs[3] === 1'b0) vfall.push_back(k);
         if (prev === 1'b0 && vs[3] === 1'b1) vrise.push_back(k);
         if (fs[3] === 1'b1) fsq.push_back(k);
         prev = vs[3];
      end
      n_checks++;
      if (vfall.size() < 1 || vrise.size() < 1 || fsq.size() < 3) begin
         n_fail++;
         $display("FAIL vs_edges got %0d/%0d/%0d exp >=1/>=1/>=3",
                  vfall.size(), vrise.size(), fsq.size());
      end else begin
         if (vfall[0] !== 228) begin
            n_fail++;
            $display("FAIL vs_fall got E%0d exp E228", vfall[0]);
         end
         n_checks++;
         if (vrise[0] - vfall[0] !== 50) begin
            n_fail++;
            $display("FAIL vs_width got %0d exp 50",
                     vrise[0] - vfall[0]);
         end
         n_checks++;
         if (fsq[1] - fsq[0] !== 325 || fsq[2] - fsq[1] !== 325) begin
            n_fail++;
            $display("FAIL fs_period got %0d,%0d exp 325",
                     fsq[1] - fsq[0], fsq[2] - fsq[1]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int target;
      do_reset(2);
      target = 2 * 1344 + int'($urandom_range(200, 1000));
      while (k < target) tick();
      rst_n = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (act(i) !== RST_OBS) begin
            n_fail++;
            $display("FAIL midreset inst%0d got %h exp %h",
                     i, act(i), RST_OBS);
         end
      end
      rst_n = 1'b1;
      for (int j = 0; j < 60; j++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (act(i) !== model(k, i)) begin
               n_fail++;
               $display("FAIL restart inst%0d k=%0d got %h exp %h",
                        i, k, act(i), model(k, i));
            end
         end
      end
   endtask

   task automatic test_random();
      int len;
      for (int r = 0; r < 4; r++) begin
         do_reset(int'($urandom_range(1, 4)));
         len = int'($urandom_range(100, 2500));
         for (int j = 0; j < len; j++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
               n_checks++;
               if (act(i) !== model(k, i)) begin
                  n_fail++;
                  $display("FAIL random inst%0d k=%0d got %h exp %h",
                           i, k, act(i), model(k, i));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_alignment();
      test_hsync();
      test_small_frame();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
